// File: rtl/iob_merge_rr.sv
// Round-robin N-master to 1-slave merge on the native bus.
// One transaction per grant; the response returns only to the granted master.
module iob_merge_rr #(
  parameter  int N_MASTERS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W    = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   last, last_nxt;
  logic [GW-1:0]   pick, cand;
  logic            found;
  logic [N_MASTERS-1:0] valid_vec;
  logic [REQ_W-1:0]     sel_req;
  logic                 s_ready;

  assign s_ready = s_resp[0];

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      valid_vec[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  // Scan last+1, last+2, ... so the most recently served master is checked last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = GW'((int'(last) + k) % N_MASTERS);
      if (!found && valid_vec[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (GW'(i) == grant) sel_req = m_req[i*REQ_W +: REQ_W];
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    s_req     = '0;
    m_resp    = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_req = sel_req;
        for (int i = 0; i < N_MASTERS; i++) begin
          if (GW'(i) == grant) m_resp[i*RESP_W +: RESP_W] = s_resp;
        end
        if (s_ready) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end else if (!sel_req[REQ_W-1]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A slave ready racing a reset must never complete a transaction.
    if (rst) m_resp = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_iob_merge_rr.sv
// Directed bench for iob_merge_rr: one instance with 2 masters, one with 3.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_iob_merge_rr;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic clk;
  logic rst2, rst3;
  logic [2*REQ_W-1:0]  m_req2;
  logic [2*RESP_W-1:0] m_resp2;
  logic [REQ_W-1:0]    s_req2;
  logic [RESP_W-1:0]   s_resp2;
  logic [3*REQ_W-1:0]  m_req3;
  logic [3*RESP_W-1:0] m_resp3;
  logic [REQ_W-1:0]    s_req3;
  logic [RESP_W-1:0]   s_resp3;

  int checks = 0;
  int errors = 0;

  iob_merge_rr #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .clk(clk), .rst(rst2), .m_req(m_req2), .m_resp(m_resp2),
    .s_req(s_req2), .s_resp(s_resp2)
  );

  iob_merge_rr #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst3), .m_req(m_req3), .m_resp(m_resp3),
    .s_req(s_req3), .s_resp(s_resp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] d, input logic r);
    return {d, r};
  endfunction

  task automatic reset2();
    rst2 = 1'b1; m_req2 = '0; s_resp2 = '0;
    @(negedge clk); @(negedge clk);
    rst2 = 1'b0;
  endtask

  task automatic reset3();
    rst3 = 1'b1; m_req3 = '0; s_resp3 = '0;
    @(negedge clk); @(negedge clk);
    rst3 = 1'b0;
  endtask

  task automatic test_reset();
    reset2(); reset3();
    #1;
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL reset_s_req2 got %h want 0", s_req2); end
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL reset_m_resp2 got %h want 0", m_resp2); end
    checks++; if (s_req3 !== '0) begin errors++; $display("FAIL reset_s_req3 got %h want 0", s_req3); end
    checks++; if (m_resp3 !== '0) begin errors++; $display("FAIL reset_m_resp3 got %h want 0", m_resp3); end
  endtask

  task automatic test_single_read();
    logic [REQ_W-1:0] r0;
    logic [2*RESP_W-1:0] exp;
    reset2();
    r0 = mk_req(1'b1, 32'h10, 32'h0, 4'h0);
    m_req2[0 +: REQ_W] = r0;
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL single_arb_cycle valid got %b want 0", s_req2[REQ_W-1]); end
    @(negedge clk); #1;
    checks++; if (s_req2 !== r0) begin errors++; $display("FAIL single_s_req got %h want %h", s_req2, r0); end
    @(negedge clk); #1;
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL single_wait_resp got %h want 0", m_resp2); end
    @(negedge clk);
    s_resp2 = mk_resp(32'hDEADBEEF, 1'b1);
    #1;
    exp = '0; exp[0 +: RESP_W] = mk_resp(32'hDEADBEEF, 1'b1);
    checks++; if (m_resp2 !== exp) begin errors++; $display("FAIL single_m_resp got %h want %h", m_resp2, exp); end
    @(negedge clk);
    s_resp2 = '0; m_req2 = '0;
    #1;
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL single_back_idle got %h want 0", s_req2); end
  endtask

  task automatic test_all_three();
    logic [REQ_W-1:0] r [3];
    logic [3*RESP_W-1:0] exp;
    reset3();
    r[0] = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
    r[1] = mk_req(1'b1, 32'h200, 32'h0, 4'h0);
    r[2] = mk_req(1'b1, 32'h300, 32'hA5A5A5A5, 4'hF);
    for (int k = 0; k < 3; k++) m_req3[k*REQ_W +: REQ_W] = r[k];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (s_req3 !== r[k]) begin errors++; $display("FAIL rr3_order_%0d got %h want %h", k, s_req3, r[k]); end
      s_resp3 = mk_resp(32'h1000 + k, 1'b1);
      #1;
      exp = '0; exp[k*RESP_W +: RESP_W] = mk_resp(32'h1000 + k, 1'b1);
      checks++; if (m_resp3 !== exp) begin errors++; $display("FAIL rr3_resp_%0d got %h want %h", k, m_resp3, exp); end
      @(negedge clk);
      s_resp3 = '0; m_req3[k*REQ_W +: REQ_W] = '0;
      #1;
      checks++; if (s_req3[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL rr3_idle_%0d valid got %b want 0", k, s_req3[REQ_W-1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [REQ_W-1:0] a, b, c;
    reset2();
    a = mk_req(1'b1, 32'h20, 32'h0, 4'h0);
    b = mk_req(1'b1, 32'h40, 32'h0, 4'h0);
    c = mk_req(1'b1, 32'h24, 32'h0, 4'h0);
    m_req2 = {b, a};
    @(negedge clk); #1;
    checks++; if (s_req2 !== a) begin errors++; $display("FAIL b2b_first_m0 got %h want %h", s_req2, a); end
    s_resp2 = mk_resp(32'h1, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2[0 +: REQ_W] = c;
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL b2b_arb_gap valid got %b want 0", s_req2[REQ_W-1]); end
    @(negedge clk); #1;
    checks++; if (s_req2 !== b) begin errors++; $display("FAIL b2b_then_m1 got %h want %h", s_req2, b); end
    s_resp2 = mk_resp(32'h2, 1'b1);
    #1;
    checks++; if (m_resp2 !== {mk_resp(32'h2, 1'b1), 33'h0}) begin errors++; $display("FAIL b2b_m1_resp got %h want %h", m_resp2, {mk_resp(32'h2, 1'b1), 33'h0}); end
    @(negedge clk);
    s_resp2 = '0; m_req2[REQ_W +: REQ_W] = '0;
    @(negedge clk); #1;
    checks++; if (s_req2 !== c) begin errors++; $display("FAIL b2b_then_m0 got %h want %h", s_req2, c); end
    s_resp2 = mk_resp(32'h3, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2 = '0;
  endtask

  task automatic test_abort();
    logic [REQ_W-1:0] a, b, c, d;
    reset2();
    a = mk_req(1'b1, 32'h50, 32'h0, 4'h0);
    b = mk_req(1'b1, 32'h60, 32'h11223344, 4'h3);
    c = mk_req(1'b1, 32'h70, 32'h0, 4'h0);
    d = mk_req(1'b1, 32'h80, 32'h0, 4'h0);
    m_req2[0 +: REQ_W] = a;
    @(negedge clk);
    s_resp2 = mk_resp(32'h0, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2 = {b, 69'h0};
    @(negedge clk); #1;
    checks++; if (s_req2 !== b) begin errors++; $display("FAIL abort_m1_granted got %h want %h", s_req2, b); end
    m_req2 = '0;
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL abort_valid_follows got %b want 0", s_req2[REQ_W-1]); end
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL abort_no_resp got %h want 0", m_resp2); end
    @(negedge clk);
    m_req2 = {d, c};
    #1;
    checks++; if (s_req2[REQ_W-1] !== 1'b0) begin errors++; $display("FAIL abort_idle valid got %b want 0", s_req2[REQ_W-1]); end
    @(negedge clk); #1;
    checks++; if (s_req2 !== d) begin errors++; $display("FAIL abort_m1_again got %h want %h", s_req2, d); end
    s_resp2 = mk_resp(32'h5, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2[REQ_W +: REQ_W] = '0;
    @(negedge clk); #1;
    checks++; if (s_req2 !== c) begin errors++; $display("FAIL abort_m0_next got %h want %h", s_req2, c); end
    s_resp2 = mk_resp(32'h6, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2 = '0;
  endtask

  task automatic test_reset_mid_busy();
    logic [REQ_W-1:0] a, b;
    reset2();
    a = mk_req(1'b1, 32'h90, 32'h0, 4'h0);
    b = mk_req(1'b1, 32'h94, 32'h0, 4'h0);
    m_req2[0 +: REQ_W] = a;
    @(negedge clk); #1;
    checks++; if (s_req2 !== a) begin errors++; $display("FAIL rstbusy_granted got %h want %h", s_req2, a); end
    rst2 = 1'b1;
    @(negedge clk);
    s_resp2 = mk_resp(32'hCAFEF00D, 1'b1);
    #1;
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL rstbusy_no_ready got %h want 0", m_resp2); end
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL rstbusy_s_req got %h want 0", s_req2); end
    @(negedge clk);
    s_resp2 = '0; rst2 = 1'b0; m_req2 = {b, a};
    #1;
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL rstbusy_after got %h want 0", s_req2); end
    @(negedge clk); #1;
    checks++; if (s_req2 !== a) begin errors++; $display("FAIL rstbusy_first_m0 got %h want %h", s_req2, a); end
    s_resp2 = mk_resp(32'h77, 1'b1);
    #1;
    checks++; if (m_resp2 !== {33'h0, mk_resp(32'h77, 1'b1)}) begin errors++; $display("FAIL rstbusy_m0_resp got %h want %h", m_resp2, {33'h0, mk_resp(32'h77, 1'b1)}); end
    @(negedge clk);
    s_resp2 = '0; m_req2 = '0;
    @(negedge clk);
  endtask

  task automatic test_spurious_ready();
    logic [REQ_W-1:0] a;
    reset2();
    a = mk_req(1'b1, 32'hA0, 32'h0, 4'h0);
    s_resp2 = mk_resp(32'h12345678, 1'b1);
    #1;
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL spur_idle_resp got %h want 0", m_resp2); end
    checks++; if (s_req2 !== '0) begin errors++; $display("FAIL spur_idle_s_req got %h want 0", s_req2); end
    @(negedge clk);
    m_req2[0 +: REQ_W] = a;
    #1;
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL spur_arb_resp got %h want 0", m_resp2); end
    @(negedge clk);
    s_resp2 = '0;
    #1;
    checks++; if (s_req2 !== a) begin errors++; $display("FAIL spur_then_grant got %h want %h", s_req2, a); end
    checks++; if (m_resp2 !== '0) begin errors++; $display("FAIL spur_busy_resp got %h want 0", m_resp2); end
    s_resp2 = mk_resp(32'h9, 1'b1);
    @(negedge clk);
    s_resp2 = '0; m_req2 = '0;
  endtask

  initial begin
    rst2 = 1'b1; rst3 = 1'b1;
    m_req2 = '0; s_resp2 = '0;
    m_req3 = '0; s_resp3 = '0;
    test_reset();
    test_single_read();
    test_all_three();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    test_spurious_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
